// File: rtl/keypad_color_writer.sv
// ============================================================================
// Module      : keypad_color_writer
// Description : 4x4 keypad scanner with debounce that advances a 16 x 3-bit
//               color-index bank; the bank is read combinationally via posicion.
// Option      : AUTO_REPEAT_EN - held key re-writes every REPEAT_CNT cycles
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_color_writer #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 50000,
    parameter int REPEAT_CNT   = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    input  logic [3:0] posicion,
    output logic [2:0] dirColor,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [2:0] wr_data
);

    localparam int c_scan_w = $clog2(SCAN_DIV) + 1;
    localparam int c_deb_w  = $clog2(DEBOUNCE_CNT) + 1;
    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_deb_w-1:0]  c_deb_max   = c_deb_w'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_WRITE    = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Elaboration-time sanity check of the timing parameters.
    if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 1) begin : g_bad_param
        $error("keypad_color_writer: invalid timing parameter");
    end

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_col, w_col_nxt;
    logic [1:0]          r_row, w_row_nxt;
    logic [c_scan_w-1:0] r_scan_cnt, w_scan_nxt, w_scan_inc;
    logic [c_deb_w-1:0]  r_deb_cnt, w_deb_nxt, w_deb_inc;
    logic [2:0]          r_bank [16];
    logic [3:0]          r_key_code;
    logic [2:0]          r_wr_data;
    logic                w_wr_en;
    logic                w_any_low;
    logic [1:0]          w_low_row;
    logic [3:0]          w_idx;
    logic [2:0]          w_new;

`ifdef AUTO_REPEAT_EN
    localparam int c_rep_w = $clog2(REPEAT_CNT) + 1;
    localparam logic [c_rep_w-1:0] c_rep_max = c_rep_w'(REPEAT_CNT);
    logic [c_rep_w-1:0]  r_rep_cnt, w_rep_nxt, w_rep_inc;
    assign w_rep_inc = (r_rep_cnt == '1) ? r_rep_cnt : r_rep_cnt + 1'b1;
`endif

    // Saturating increments: counters never wrap back to zero.
    assign w_scan_inc = (r_scan_cnt == '1) ? r_scan_cnt : r_scan_cnt + 1'b1;
    assign w_deb_inc  = (r_deb_cnt == '1) ? r_deb_cnt : r_deb_cnt + 1'b1;

    assign w_any_low = ~&row_n;

    always_comb begin
        w_low_row = 2'd0;
        if (!row_n[0])      w_low_row = 2'd0;
        else if (!row_n[1]) w_low_row = 2'd1;
        else if (!row_n[2]) w_low_row = 2'd2;
        else if (!row_n[3]) w_low_row = 2'd3;
    end

    // Top-left key is index 15; indices fall by 4 per column, 1 per row.
    assign w_idx = 4'd15 - {r_col, 2'b00} - {2'b00, r_row};
    assign w_new = r_bank[w_idx] + 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_scan_nxt  = r_scan_cnt;
        w_deb_nxt   = r_deb_cnt;
        w_wr_en     = 1'b0;
`ifdef AUTO_REPEAT_EN
        w_rep_nxt   = r_rep_cnt;
`endif
        case (r_state)
            ST_SCAN: begin
                if (r_scan_cnt >= c_scan_last) begin
                    w_scan_nxt = '0;
                    if (w_any_low) begin
                        w_row_nxt   = w_low_row;
                        w_deb_nxt   = '0;
                        w_state_nxt = ST_DEBOUNCE;
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end else begin
                    w_scan_nxt = w_scan_inc;
                end
            end
            ST_DEBOUNCE: begin
                if (!row_n[r_row]) begin
                    if (w_deb_inc >= c_deb_max) begin
                        w_deb_nxt   = '0;
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_deb_nxt = w_deb_inc;
                    end
                end else begin
                    w_deb_nxt   = '0;
                    w_scan_nxt  = '0;
                    w_col_nxt   = r_col + 2'd1;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_WRITE: begin
                w_wr_en     = 1'b1;
                w_deb_nxt   = '0;
`ifdef AUTO_REPEAT_EN
                w_rep_nxt   = '0;
`endif
                w_state_nxt = ST_RELEASE;
            end
            default: begin // ST_RELEASE
                if (!w_any_low) begin
`ifdef AUTO_REPEAT_EN
                    w_rep_nxt = '0;
`endif
                    if (w_deb_inc >= c_deb_max) begin
                        w_deb_nxt   = '0;
                        w_scan_nxt  = '0;
                        w_col_nxt   = r_col + 2'd1;
                        w_state_nxt = ST_SCAN;
                    end else begin
                        w_deb_nxt = w_deb_inc;
                    end
                end else begin
                    w_deb_nxt = '0;
`ifdef AUTO_REPEAT_EN
                    // Only the latched row drives the repeat timer.
                    if (!row_n[r_row]) begin
                        if (w_rep_inc >= c_rep_max) begin
                            w_rep_nxt   = '0;
                            w_state_nxt = ST_WRITE;
                        end else begin
                            w_rep_nxt = w_rep_inc;
                        end
                    end else begin
                        w_rep_nxt = '0;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_SCAN;
            r_col      <= 2'd0;
            r_row      <= 2'd0;
            r_scan_cnt <= '0;
            r_deb_cnt  <= '0;
            r_key_code <= 4'd0;
            r_wr_data  <= 3'd0;
`ifdef AUTO_REPEAT_EN
            r_rep_cnt  <= '0;
`endif
            for (int i = 0; i < 16; i++) begin
                r_bank[i] <= 3'd0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_scan_cnt <= w_scan_nxt;
            r_deb_cnt  <= w_deb_nxt;
`ifdef AUTO_REPEAT_EN
            r_rep_cnt  <= w_rep_nxt;
`endif
            if (w_wr_en) begin
                r_bank[w_idx] <= w_new;
                r_key_code    <= w_idx;
                r_wr_data     <= w_new;
            end
        end
    end

    assign col_n     = ~(4'b0001 << r_col);
    assign dirColor  = r_bank[posicion];
    // During the write cycle the pulse carries the value being written.
    assign key_valid = (r_state == ST_WRITE);
    assign key_code  = key_valid ? w_idx : r_key_code;
    assign wr_data   = key_valid ? w_new : r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_keypad_color_writer.sv
// ============================================================================
// Module      : tb_keypad_color_writer
// Description : Scoreboard bench for keypad_color_writer with a keypad matrix model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_keypad_color_writer;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;
    localparam int REPEAT_CNT   = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] posicion;
    logic [2:0] dirColor;
    logic       key_valid;
    logic [3:0] key_code;
    logic [2:0] wr_data;

    logic [15:0] keys;          // bit r*4+c set = key (r,c) pressed
    logic [6:0]  exp_q [$];     // {key_code, wr_data}
    logic [6:0]  exp_item;
    logic [2:0]  model [16];
    logic        prev_valid = 1'b0;
    int          checks = 0;
    int          errors = 0;

    keypad_color_writer #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .REPEAT_CNT  (REPEAT_CNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col_n    (col_n),
        .row_n    (row_n),
        .posicion (posicion),
        .dirColor (dirColor),
        .key_valid(key_valid),
        .key_code (key_code),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its row low when its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL pulse_width: key_valid high on consecutive cycles, required one-cycle pulse");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got code %0d data %0d, no write expected", key_code, wr_data);
            end else begin
                exp_item = exp_q.pop_front();
                if ({key_code, wr_data} !== exp_item) begin
                    errors++;
                    $display("FAIL write_event: got code %0d data %0d, required code %0d data %0d",
                             key_code, wr_data, exp_item[6:3], exp_item[2:0]);
                end
            end
        end
        prev_valid = key_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic check_bank(input string tag);
        for (int p = 0; p < 16; p++) begin
            posicion = 4'(p);
            #1;
            check($sformatf("%s_bank%0d", tag, p), 32'(dirColor), 32'(model[p]));
        end
    endtask

    task automatic expect_write(input int idx);
        model[idx] = model[idx] + 3'd1;
        exp_q.push_back({4'(idx), model[idx]});
    endtask

    task automatic press(input int r, input int c, input int hold);
        keys[r*4+c] = 1'b1;
        tick(hold);
        keys[r*4+c] = 1'b0;
    endtask

    initial begin
        logic [3:0] col_start;
        bit         moved;

        rst      = 1'b0;
        keys     = 16'h0;
        posicion = 4'd0;
        for (int i = 0; i < 16; i++) model[i] = 3'd0;
        tick(2);
        check("reset_col_n", 32'(col_n), 32'b1110);
        check("reset_key_valid", 32'(key_valid), 0);
        check("reset_key_code", 32'(key_code), 0);
        check_bank("reset");
        rst = 1'b1;

        // Single press on top-left key (index 15).
        expect_write(15);
        press(0, 0, 30);
        tick(20);
        check_bank("single");
        check("single_drained", 32'(exp_q.size()), 0);

        // Bottom-right key (index 0) eight times wraps back to white.
        for (int i = 0; i < 8; i++) begin
            expect_write(0);
            press(3, 3, 30);
            tick(20);
        end
        posicion = 4'd0;
        #1;
        check("wrap_final", 32'(dirColor), 0);
        check("wrap_drained", 32'(exp_q.size()), 0);

        // Bouncing key r1,c2 (index 6) never stays low long enough.
        for (int k = 0; k < 7; k++) begin
            keys[6] = 1'b1;
            tick(3);
            keys[6] = 1'b0;
            tick(3);
        end
        tick(10);
        col_start = col_n;
        moved = 1'b0;
        for (int k = 0; k < 20 && !moved; k++) begin
            tick(1);
            if (col_n != col_start) moved = 1'b1;
        end
        check("bounce_scan_resumes", 32'(moved), 1);
        check_bank("bounce");

        // Held key r2,c1 (index 9).
`ifdef AUTO_REPEAT_EN
        for (int k = 0; k < 1 + (200 - DEBOUNCE_CNT - 2) / (REPEAT_CNT + 1); k++) expect_write(9);
`else
        expect_write(9);
`endif
        press(2, 1, 200);
        tick(30);
        check("held_drained", 32'(exp_q.size()), 0);
        check("held_key_code_hold", 32'(key_code), 9);
        check("held_wr_data_hold", 32'(wr_data), 32'(model[9]));
        check_bank("held");

        // Reset four cycles into debounce of r0,c0.
        moved = 1'b0;
        for (int k = 0; k < 20 && !moved; k++) begin
            tick(1);
            if (col_n != 4'b1110) moved = 1'b1;
        end
        moved = 1'b0;
        for (int k = 0; k < 20 && !moved; k++) begin
            tick(1);
            if (col_n == 4'b1110) moved = 1'b1;
        end
        check("midrst_col0_found", 32'(moved), 1);
        keys[0] = 1'b1;
        tick(SCAN_DIV + 4);
        rst = 1'b0;
        keys[0] = 1'b0;
        tick(2);
        for (int i = 0; i < 16; i++) model[i] = 3'd0;
        check("midrst_col_n", 32'(col_n), 32'b1110);
        check("midrst_key_code", 32'(key_code), 0);
        check("midrst_wr_data", 32'(wr_data), 0);
        check_bank("midrst");
        rst = 1'b1;
        tick(30);
        check("final_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
